cs_result_converter: RTL and testbench
======================================

Name: cs_result_converter

Overview:
- Downstream of the last radix-4 PE in the scalable Montgomery multiplier chain.
- Accepts the final carry-save result word-serially, LSB word first, as aligned (sum, carry) word pairs, along with the matching modulus words.
- Resolves the pair to binary with a word-serial carry chain, computes R-N in parallel, buffers both, and streams out the reduced K-bit result (R if R<N, else R-N).

Parameters:
- K, 1024, operand full size in bits.
- W, 16, word size in bits; K must be a multiple of W.
- NW, K/W, words per operand (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word pair valid.
- in_ready  output  1  converter can accept an input word.
- in_sum  input  W  carry-save sum word.
- in_carry  input  W  carry-save carry word, same weight as in_sum.
- in_n  input  W  modulus word, same weight.
- out_valid  output  1  result word valid.
- out_ready  input  1  consumer accepts the result word.
- out_word  output  W  reduced result word, LSB word first.
- out_last  output  1  high with word NW-1.
- out_sub  output  1  result is R-N; held for the whole output burst.

Behaviour:
- States: ACCUM, DECIDE, DRAIN.
- Reset (any state, including mid-burst):
  - state=ACCUM; word counter=0; cin=0; bin=0.
  - out_valid=0, out_last=0, out_sub=0, out_word=0.
  - Buffer contents are don't-care.
- ACCUM:
  - in_ready=1. On in_valid&in_ready, word i is accepted.
  - {c, r} = in_sum + in_carry + cin, giving W+1 bits; c becomes the next cin.
  - {b, d} = r - in_n - bin; b becomes the next bin.
  - r is written to buffer R[i]; d is written to buffer D[i]; counter increments.
  - Idle cycles (in_valid=0) hold all state.
  - Accepting word NW-1: counter wraps to 0, go to DECIDE. in_ready is 0 in DECIDE and DRAIN.
- DECIDE (exactly 1 cycle):
  - sel = final cout | ~final bout. Because R<2N<2^(K+1), D fits in K bits whenever sel=1.
  - Latch sel into out_sub; clear cin and bin; go to DRAIN.
- DRAIN:
  - out_valid=1; out_word = sel ? D[j] : R[j]; out_last = (j==NW-1).
  - On out_valid&out_ready, j increments.
  - With out_ready=0, out_word, out_last and out_sub are held stable.
  - After word NW-1 is accepted: out_valid=0, out_sub=0, j=0, go to ACCUM.
- Latency:
  - Last input word accepted at cycle t gives out_valid=1 with word 0 at t+2.
  - With out_ready held high, one output word per cycle.
  - Minimum throughput is NW+1+NW cycles per operand. No overlap of input and output.
- Arithmetic:
  - All unsigned. cin and bin are 1 bit and reset to 0 at the start of every operand.
  - R==N gives sel=1 and an all-zero output.
- Buffers: two NW x W register arrays (or inferred RAM), single write port in ACCUM, single read port in DRAIN.

Optional Feature:
- Macro CONV_FINAL_SUB_EN.
- Defined: behaviour as above.
- Undefined:
  - No D buffer and no subtract chain; DRAIN always outputs R[j].
  - out_sub instead reports the final cout (overflow bit 2^K), latched in DECIDE.
  - Handshake, latency and reset behaviour are unchanged.

Test Plan (K=64, W=16, NW=4):
- Small, no subtract: N words {7,0,0,0}, sum {3,0,0,0}, carry {2,0,0,0} -> out {5,0,0,0}, out_sub=0, out_last on 4th word, first out_valid two cycles after last input.
- Full ripple plus overflow: sum {FFFF,FFFF,FFFF,FFFF}, carry {0001,0,0,0}, N {0,0,0,8000} -> R=2^64, out {0,0,0,8000}, out_sub=1. Without CONV_FINAL_SUB_EN: out {0,0,0,0}, out_sub=1.
- Equality: N {DEF1,9ABC,5678,1234}, sum=N, carry {0,0,0,0} -> out {0,0,0,0}, out_sub=1.
- Backpressure: repeat the small case with out_ready toggling 1,0,1,0... -> out_word and out_last stable while out_ready=0, exactly 4 words {5,0,0,0}, in_ready=0 until the burst completes.
- Input gaps: the ripple case with 2 idle cycles between every input word -> identical output to the no-gap run.
- Reset mid-operation: assert rst after 2 input words, then after 3 output words of another run -> next cycle in_ready=1, out_valid=0, out_sub=0; a fresh small-case operand then yields {5,0,0,0}.

Source files
------------

// File: rtl/cs_result_converter.sv
// rtl/cs_result_converter.sv - carry-save to binary converter with final Montgomery subtraction
//
// Sits after the last radix-4 PE of the scalable Montgomery multiplier chain.
// The final carry-save result arrives word-serially (LSB word first) as
// aligned (sum, carry) pairs together with the matching modulus word. A
// word-serial carry chain resolves R = sum + carry, a parallel borrow chain
// forms D = R - N, both are buffered, and the reduced K-bit result is then
// streamed out (D when R >= N or R overflowed K bits, else R).
//
// Optional feature macro: CONV_FINAL_SUB_EN
//   defined   : D buffer and subtract chain present; out_sub = "R-N selected".
//   undefined : no D buffer; output is always R and out_sub reports the
//               final carry-out (bit 2^K) of the sum+carry resolution.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   input word pair valid
//   in_ready   out  converter can accept an input word (ACCUM only)
//   in_sum     in   W  carry-save sum word
//   in_carry   in   W  carry-save carry word, same weight as in_sum
//   in_n       in   W  modulus word, same weight
//   out_valid  out  result word valid (DRAIN only)
//   out_ready  in   consumer accepts the result word
//   out_word   out  W  reduced result word, LSB word first
//   out_last   out  high with the final word of the burst
//   out_sub    out  select/overflow flag, held for the whole output burst

module cs_result_converter #(
    parameter  int K  = 1024,
    parameter  int W  = 16,
    localparam int NW = K / W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    input  logic [W-1:0] in_n,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_word,
    output logic         out_last,
    output logic         out_sub
);

    localparam int            CW   = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DECIDE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    // One counter serves as the write index in ACCUM and the read index in
    // DRAIN; it is always 0 on entry to either phase.
    logic [CW-1:0] r_cnt;
    logic          r_cin;
    logic          r_sub;

    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_cnt_last;
    logic          w_sel;

    // Word-serial carry resolution: {c, r} = sum + carry + cin.
    logic [W:0]    w_add;

    logic [W-1:0]  r_rbuf [NW];

`ifdef CONV_FINAL_SUB_EN
    logic          r_bin;
    // Borrow chain on the freshly resolved word: {b, d} = r - n - bin.
    // Operands are zero-extended, so bit W is set exactly when a borrow occurs.
    logic [W:0]    w_diff;
    logic [W-1:0]  r_dbuf [NW];
`else
    logic          w_unused_n;
`endif

    assign w_cnt_last = (r_cnt == LAST);
    assign w_add      = {1'b0, in_sum} + {1'b0, in_carry} + {{W{1'b0}}, r_cin};

`ifdef CONV_FINAL_SUB_EN
    assign w_diff = {1'b0, w_add[W-1:0]} - {1'b0, in_n} - {{W{1'b0}}, r_bin};
    // R >= 2^K always needs the subtraction; otherwise a final borrow means R < N.
    assign w_sel  = r_cin | ~r_bin;
`else
    assign w_unused_n = ^in_n;
    assign w_sel      = r_cin;
`endif

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_word    = '0;
        w_in_fire   = 1'b0;
        w_out_fire  = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_in_fire = 1'b1;
                    if (w_cnt_last) begin
                        w_state_nxt = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_last  = w_cnt_last;
`ifdef CONV_FINAL_SUB_EN
                out_word  = r_sub ? r_dbuf[r_cnt] : r_rbuf[r_cnt];
`else
                out_word  = r_rbuf[r_cnt];
`endif
                if (out_ready) begin
                    w_out_fire = 1'b1;
                    if (w_cnt_last) begin
                        w_state_nxt = ST_ACCUM;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    assign out_sub = r_sub;

    // Control state: FSM, counter, carry/borrow chain bits and the output flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_cnt   <= '0;
            r_cin   <= 1'b0;
            r_sub   <= 1'b0;
`ifdef CONV_FINAL_SUB_EN
            r_bin   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;

            if (w_in_fire) begin
                r_cin <= w_add[W];
`ifdef CONV_FINAL_SUB_EN
                r_bin <= w_diff[W];
`endif
                r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
            end

            // Chains are consumed here and cleared so the next operand starts clean.
            if (r_state == ST_DECIDE) begin
                r_sub <= w_sel;
                r_cin <= 1'b0;
`ifdef CONV_FINAL_SUB_EN
                r_bin <= 1'b0;
`endif
            end

            if (w_out_fire) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
                if (w_cnt_last) begin
                    r_sub <= 1'b0;
                end
            end
        end
    end

    // Result buffers: written once per accepted input word, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_rbuf[r_cnt] <= w_add[W-1:0];
`ifdef CONV_FINAL_SUB_EN
            r_dbuf[r_cnt] <= w_diff[W-1:0];
`endif
        end
    end

endmodule

// File: tb/tb_cs_result_converter.sv
// tb/tb_cs_result_converter.sv - self-checking bench for cs_result_converter
module tb_cs_result_converter;

    localparam int K  = 64;
    localparam int W  = 16;
    localparam int NW = K / W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic [W-1:0] in_carry;
    logic [W-1:0] in_n;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_word;
    logic         out_last;
    logic         out_sub;

    cs_result_converter #(.K(K), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .in_carry (in_carry),
        .in_n     (in_n),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_last (out_last),
        .out_sub  (out_sub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] w;
        logic         l;
        logic         s;
    } exp_t;

    typedef struct {
        logic [K-1:0] s;
        logic [K-1:0] c;
        logic [K-1:0] n;
        logic [K-1:0] eo;
        logic         es;
        int           gap;
        int           mode;
        bit           lat;
    } vec_t;

    exp_t sb[$];
    vec_t tv[5];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [K-1:0] s, input logic [K-1:0] c,
                                  input logic [K-1:0] n,
                                  output logic [K-1:0] o, output logic sub);
        logic [K:0] r;
        r = {1'b0, s} + {1'b0, c};
`ifdef CONV_FINAL_SUB_EN
        if (r[K] || (r[K-1:0] >= n)) begin
            o   = r[K-1:0] - n;
            sub = 1'b1;
        end else begin
            o   = r[K-1:0];
            sub = 1'b0;
        end
`else
        o   = r[K-1:0];
        sub = r[K];
`endif
    endfunction

    task automatic push_exp(input logic [K-1:0] eo, input logic es);
        exp_t e;
        for (int i = 0; i < NW; i++) begin
            e.w = eo[i*W +: W];
            e.l = (i == NW - 1);
            e.s = es;
            sb.push_back(e);
        end
    endtask

    // Entered and left at posedge+1; no idle gap after the final word.
    task automatic send_words(input logic [K-1:0] s, input logic [K-1:0] c,
                              input logic [K-1:0] n, input int gap, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int to;
            to       = 0;
            in_valid = 1'b1;
            in_sum   = s[i*W +: W];
            in_carry = c[i*W +: W];
            in_n     = n[i*W +: W];
            @(negedge clk);
            while (!in_ready && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (to >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (i != cnt - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready toggles 1,0,1,0...
    task automatic receive(input int mode, input bit chk_lat, input int nwords, input bit end_chk);
        int           got;
        int           cyc;
        bit           first;
        bit           held;
        logic [W-1:0] pw;
        logic         pl;
        logic         ps;
        exp_t         e;
        got       = 0;
        cyc       = 0;
        first     = 1'b1;
        held      = 1'b0;
        pw        = '0;
        pl        = 1'b0;
        ps        = 1'b0;
        out_ready = 1'b1;
        while (got < nwords && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (first) begin
                    first = 1'b0;
                    if (chk_lat) chk("latency", 64'(cyc), 64'd2);
                end
                chk("in_ready_in_drain", 64'(in_ready), 64'd0);
                if (held) begin
                    chk("stall_word", 64'(out_word), 64'(pw));
                    chk("stall_last", 64'(out_last), 64'(pl));
                    chk("stall_sub", 64'(out_sub), 64'(ps));
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("scoreboard_empty", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("word%0d", got), 64'(out_word), 64'(e.w));
                        chk($sformatf("last%0d", got), 64'(out_last), 64'(e.l));
                        chk($sformatf("sub%0d", got), 64'(out_sub), 64'(e.s));
                    end
                    got++;
                    held = 1'b0;
                end else begin
                    pw   = out_word;
                    pl   = out_last;
                    ps   = out_sub;
                    held = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (mode == 1) out_ready = ~out_ready;
        end
        if (got < nwords) chk("out_timeout", 64'(got), 64'(nwords));
        out_ready = 1'b0;
        if (end_chk) begin
            @(negedge clk);
            chk("post_valid", 64'(out_valid), 64'd0);
            chk("post_sub", 64'(out_sub), 64'd0);
            chk("post_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input vec_t v);
        push_exp(v.eo, v.es);
        send_words(v.s, v.c, v.n, v.gap, NW);
        receive(v.mode, v.lat, NW, 1'b1);
    endtask

    task automatic pulse_reset_and_check();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sub", 64'(out_sub), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         v;
        logic [K-1:0] mo;
        logic         ms;

        // small case
        tv[0] = '{s: 64'h3, c: 64'h2, n: 64'h7, eo: 64'h5, es: 1'b0, gap: 0, mode: 0, lat: 1'b1};
        // full ripple plus overflow
        tv[1] = '{s: 64'hFFFF_FFFF_FFFF_FFFF, c: 64'h1, n: 64'h8000_0000_0000_0000,
`ifdef CONV_FINAL_SUB_EN
                  eo: 64'h8000_0000_0000_0000, es: 1'b1,
`else
                  eo: 64'h0, es: 1'b1,
`endif
                  gap: 0, mode: 0, lat: 1'b1};
        // equality
        tv[2] = '{s: 64'h1234_5678_9ABC_DEF1, c: 64'h0, n: 64'h1234_5678_9ABC_DEF1,
`ifdef CONV_FINAL_SUB_EN
                  eo: 64'h0, es: 1'b1,
`else
                  eo: 64'h1234_5678_9ABC_DEF1, es: 1'b0,
`endif
                  gap: 0, mode: 0, lat: 1'b1};
        // backpressure on the small case
        tv[3] = tv[0];
        tv[3].mode = 1;
        // ripple case with two idle cycles between input words
        tv[4] = tv[1];
        tv[4].gap = 2;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        in_n      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_last", 64'(out_last), 64'd0);
        chk("reset_out_sub", 64'(out_sub), 64'd0);
        chk("reset_out_word", 64'(out_word), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_op(tv[i]);

        // randomised operands checked against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            v.s    = {$urandom, $urandom};
            v.c    = (i % 2 == 0) ? {$urandom, $urandom} : {32'h0, $urandom};
            v.n    = {1'b1, 31'($urandom), $urandom};
            v.gap  = i % 2;
            v.mode = (i >= 3) ? 1 : 0;
            v.lat  = (v.gap == 0);
            model(v.s, v.c, v.n, mo, ms);
            v.eo   = mo;
            v.es   = ms;
            run_op(v);
        end

        // reset after two input words
        send_words(tv[0].s, tv[0].c, tv[0].n, 0, 2);
        pulse_reset_and_check();

        // reset after three output words of a ripple run
        push_exp(tv[1].eo, tv[1].es);
        send_words(tv[1].s, tv[1].c, tv[1].n, 0, NW);
        receive(0, 1'b1, 3, 1'b0);
        pulse_reset_and_check();

        // fresh small operand after reset
        run_op(tv[0]);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
